// File: rtl/dram_buf_scheduler.sv
// -----------------------------------------------------------------------------
// dram_buf_scheduler
//
// Front-end scheduler for the shared dram_buffer FIFO. Round-robin arbitrates
// NUM_REQ write requesters into the buffer and drains the buffer towards the
// DRAM command path over valid/ready. At most one buffer operation is issued
// per cycle, because the buffer gives writes priority and silently drops a
// read issued in the same cycle. Under continuous write traffic a waiting
// read is forced through after RD_STARVE_MAX write grants.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   req_valid    per-requester write request
//   req_data     requester i data at [i*WIDTH +: WIDTH]
//   req_ready    one-hot write grant (transfer when req_valid & req_ready)
//   buf_datain   data to buffer datain
//   buf_wr_en    buffer write strobe
//   buf_rd_en    buffer read strobe
//   buf_dataout  buffer registered read data
//   buf_full     buffer full flag
//   buf_empty    buffer empty flag
//   out_valid    drained word available
//   out_data     drained word
//   out_ready    downstream accepts out_data
//   grant_id     index of the last granted requester (registered)
// -----------------------------------------------------------------------------
module dram_buf_scheduler #(
  parameter int WIDTH         = 8,
  parameter int NUM_REQ       = 4,
  parameter int RD_STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           buf_datain,
  output logic                       buf_wr_en,
  output logic                       buf_rd_en,
  input  logic [WIDTH-1:0]           buf_dataout,
  input  logic                       buf_full,
  input  logic                       buf_empty,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ
  } op_e;

  op_e              op;
  logic             rd_elig;
  logic             wr_elig;
  logic             rd_pend;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] starve_cnt;

  // Winner search: scanning from the far end down to rr_ptr and overwriting
  // leaves the first valid requester at or after rr_ptr (modulo NUM_REQ).
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves it unassigned and no latch is inferred.
    win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int               idx;
      logic [PTR_W-1:0] cand;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (req_valid[cand]) win_idx = cand;
    end
  end

  assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

  // A read is eligible only when its word can land: nothing in flight and the
  // output register free (or being emptied this cycle).
  assign rd_elig = !buf_empty && !rd_pend && (!out_valid || out_ready);
  assign wr_elig = (|req_valid) && !buf_full;

  // Op select and strobe generation. Reset forces IDLE so no strobe or grant
  // escapes while rst is high.
  always_comb begin
    op         = OP_IDLE;
    req_ready  = '0;
    buf_datain = '0;
    buf_wr_en  = 1'b0;
    buf_rd_en  = 1'b0;
    if (!rst) begin
      if (rd_elig && (!wr_elig || starve_cnt == CNT_W'(RD_STARVE_MAX)))
        op = OP_READ;
      else if (wr_elig)
        op = OP_WRITE;
    end
    case (op)
      OP_WRITE: begin
        req_ready[win_idx] = 1'b1;
        buf_datain         = req_data[win_idx*WIDTH +: WIDTH];
        buf_wr_en          = 1'b1;
      end
      OP_READ:  buf_rd_en = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      rd_pend    <= 1'b0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      grant_id   <= '0;
    end else begin
      if (op == OP_WRITE) begin
        rr_ptr   <= ptr_next;
        grant_id <= win_idx;
      end

      // The buffer presents read data one edge after buf_rd_en; capture it
      // on the following edge. READ requires !rd_pend, so this also clears it.
      rd_pend <= (op == OP_READ);

      // Capture wins over a same-edge downstream accept.
      if (rd_pend) begin
        out_data  <= buf_dataout;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Counts write grants taken while a read was waiting; any read or any
      // cycle without an eligible read restarts the count.
      if (op == OP_WRITE && rd_elig) begin
        if (starve_cnt != CNT_W'(RD_STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dram_buf_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dram_buf_scheduler
//
// Directed bench for dram_buf_scheduler. Buffer flags and read data are driven
// directly, cycle by cycle, and each expected value is written out by hand.
// -----------------------------------------------------------------------------
module tb_dram_buf_scheduler;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         buf_datain;
  logic                     buf_wr_en;
  logic                     buf_rd_en;
  logic [WIDTH-1:0]         buf_dataout;
  logic                     buf_full;
  logic                     buf_empty;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [1:0]               grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Starvation sequence starting at rr_ptr=1: requester index, or -1 = read.
  int t3_win [11] = '{1, 2, 3, 0, -1, 1, 2, 3, 0, 1, -1};

  dram_buf_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .RD_STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .buf_datain  (buf_datain),
    .buf_wr_en   (buf_wr_en),
    .buf_rd_en   (buf_rd_en),
    .buf_dataout (buf_dataout),
    .buf_full    (buf_full),
    .buf_empty   (buf_empty),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 4'b1111;
    req_data    = 32'h13121110;
    buf_dataout = '0;
    buf_full    = 1'b0;
    buf_empty   = 1'b0;
    out_ready   = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", buf_wr_en, 0);
    check("rst_rd_en", buf_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_grant_id", grant_id, 0);
    next_cycle;
    next_cycle;

    // Test 1: requester 2 alone writes A5, 3C, then both are drained.
    rst       = 1'b0;
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    buf_empty = 1'b1;
    #1;
    check("t1_w0_ready", req_ready, 4'b0100);
    check("t1_w0_wr", buf_wr_en, 1);
    check("t1_w0_rd", buf_rd_en, 0);
    check("t1_w0_din", buf_datain, 8'hA5);
    next_cycle;
    check("t1_w0_gid", grant_id, 2);
    req_data  = 32'h003C0000;
    buf_empty = 1'b0;
    #1;
    check("t1_w1_ready", req_ready, 4'b0100);
    check("t1_w1_din", buf_datain, 8'h3C);
    check("t1_w1_rd", buf_rd_en, 0);
    next_cycle;
    check("t1_w1_gid", grant_id, 2);
    req_valid = 4'b0000;
    #1;
    check("t1_r0_rd", buf_rd_en, 1);
    check("t1_r0_wr", buf_wr_en, 0);
    next_cycle;
    buf_dataout = 8'hA5;
    #1;
    check("t1_pend_rd", buf_rd_en, 0);
    check("t1_pend_ov", out_valid, 0);
    next_cycle;
    check("t1_cap0_ov", out_valid, 1);
    check("t1_cap0_data", out_data, 8'hA5);
    check("t1_r1_rd", buf_rd_en, 1);
    next_cycle;
    buf_dataout = 8'h3C;
    buf_empty   = 1'b1;
    #1;
    check("t1_acc_ov", out_valid, 0);
    check("t1_pend1_rd", buf_rd_en, 0);
    next_cycle;
    check("t1_cap1_ov", out_valid, 1);
    check("t1_cap1_data", out_data, 8'h3C);

    // Test 2: fresh reset, all requesters valid, no reads possible.
    rst = 1'b1;
    next_cycle;
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b0;
    buf_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_ready", req_ready, 32'(1) << (i % 4));
      check("t2_din", buf_datain, 32'h10 + (i % 4));
      check("t2_excl", buf_rd_en, 0);
      next_cycle;
      check("t2_gid", grant_id, i % 4);
    end

    // Test 3: read starvation bound, rr_ptr starts at 1.
    buf_empty = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      if (t3_win[i] < 0) begin
        check("t3_rd", buf_rd_en, 1);
        check("t3_rd_wr", buf_wr_en, 0);
        check("t3_rd_ready", req_ready, 0);
      end else begin
        check("t3_wr", buf_wr_en, 1);
        check("t3_wr_rd", buf_rd_en, 0);
        check("t3_wr_ready", req_ready, 32'(1) << t3_win[i]);
      end
      next_cycle;
    end

    // Test 4: buffer full, reads continue, writes resume at rr_ptr=2.
    buf_full    = 1'b1;
    buf_dataout = 8'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_ready", req_ready, 0);
      check("t4_wr", buf_wr_en, 0);
      check("t4_rd", buf_rd_en, i % 2);
      next_cycle;
    end
    buf_full    = 1'b0;
    buf_dataout = 8'h77;
    #1;
    check("t4_resume_ready", req_ready, 4'b0100);
    check("t4_resume_wr", buf_wr_en, 1);
    next_cycle;
    check("t4_resume_gid", grant_id, 2);
    check("t4_cap_ov", out_valid, 1);
    check("t4_cap_data", out_data, 8'h77);

    // Test 5: backpressure holds 0x77, then the read goes out with out_ready.
    out_ready = 1'b0;
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_ov", out_valid, 1);
      check("t5_hold_data", out_data, 8'h77);
      check("t5_hold_rd", buf_rd_en, 0);
      next_cycle;
    end
    out_ready = 1'b1;
    #1;
    check("t5_release_rd", buf_rd_en, 1);
    next_cycle;

    // Test 6: reset while a read is in flight.
    req_valid   = 4'b1111;
    buf_dataout = 8'hEE;
    #1;
    check("t6_pre_ready", req_ready, 4'b1000);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_wr", buf_wr_en, 0);
    check("t6_rst_rd", buf_rd_en, 0);
    check("t6_rst_gid", grant_id, 0);
    check("t6_rst_ov", out_valid, 0);
    next_cycle;
    rst       = 1'b0;
    buf_empty = 1'b1;
    #1;
    check("t6_post_ready", req_ready, 4'b0001);
    next_cycle;
    check("t6_post_gid", grant_id, 0);
    check("t6_no_stale_cap", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
